writeback_unit: RTL and testbench



---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_load_fifo.sv | 45 ++++
 rtl/writeback_unit.sv | 97 +++++++++
 tb/tb_writeback_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write side. The defaults here are also used
// by the register file itself.
package wb_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int REG_FILE_SIZE = 8;
  localparam int R_ZERO        = 0;
  localparam int R_ONE         = 1;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LD} wb_src_e;
endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO that holds load results waiting for the write port.
// It has no same-cycle pass-through: a full FIFO refuses a push even when it is popped in that cycle.
module wb_load_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap without any extra logic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results onto the single register-file write port.
// It filters out writes to r0/r1 and tracks the loads that are still outstanding for issue stalls.
module writeback_unit import wb_pkg::*; #(
  parameter int DATA_WIDTH    = wb_pkg::DATA_WIDTH,
  parameter int REG_FILE_SIZE = wb_pkg::REG_FILE_SIZE,
  parameter int ADDR_WIDTH    = $clog2(REG_FILE_SIZE),
  parameter int LQ_DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_addr,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic                         wb_wen,
  output logic [ADDR_WIDTH-1:0]        wb_addr,
  output logic [DATA_WIDTH-1:0]        wb_data,
  output logic [REG_FILE_SIZE-1:0]     busy,
  output logic                         drop,
  output logic [$clog2(LQ_DEPTH):0]    lq_count
);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic                     rdy_q, lq_full, lq_empty, lq_pop;
  logic [EW-1:0]            lq_head;
  wb_src_e                  src;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [REG_FILE_SIZE-1:0] busy_nxt;

  // rdy_q keeps ld_ready low through reset and for the cycle in which reset is released.
  assign ld_ready = rdy_q & ~lq_full;
  assign lq_pop   = (src == SRC_LD);

  wb_load_fifo #(.W(EW), .DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ld_valid & ld_ready),
    .din     ({ld_addr, ld_data}),
    .pop     (lq_pop),
    .dout    (lq_head),
    .full    (lq_full),
    .empty   (lq_empty),
    .count   (lq_count)
  );

  // The ALU is never stalled. Queued loads use the port only in cycles the ALU leaves free.
  always_comb begin
    src      = SRC_NONE;
    sel_addr = alu_addr;
    sel_data = alu_data;
    if (alu_valid) begin
      src = SRC_ALU;
    end else if (!lq_empty) begin
      src      = SRC_LD;
      sel_addr = lq_head[EW-1:DATA_WIDTH];
      sel_data = lq_head[DATA_WIDTH-1:0];
    end
  end

  // A new issue to a register overrides the clear from an older load to the same register.
  always_comb begin
    busy_nxt = busy;
    if (src == SRC_LD) busy_nxt[sel_addr] = 1'b0;
    if (iss_valid && iss_addr > ADDR_WIDTH'(R_ONE)) busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_q   <= 1'b0;
      wb_wen  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      drop    <= 1'b0;
      busy    <= '0;
    end else begin
      rdy_q  <= 1'b1;
      wb_wen <= 1'b0;
      drop   <= 1'b0;
      busy   <= busy_nxt;
      if (src != SRC_NONE) begin
        if (sel_addr > ADDR_WIDTH'(R_ONE)) begin
          wb_wen  <= 1'b1;
          wb_addr <= sel_addr;
          wb_data <= sel_data;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected port activity is queued with the cycle it should appear in.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, ld_valid, ld_ready, iss_valid;
  logic [2:0]  alu_addr, ld_addr, iss_addr, wb_addr;
  logic [31:0] alu_data, ld_data, wb_data;
  logic        wb_wen, drop;
  logic [7:0]  busy;
  logic [1:0]  lq_count;

  typedef struct {
    int          cyc;
    bit          wen;
    logic [2:0]  addr;
    logic [31:0] data;
    bit          drop;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c;

  writeback_unit dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .drop(drop), .lq_count(lq_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input int ec, input bit wen, input logic [2:0] a,
                      input logic [31:0] d, input bit dr);
    exp_t e;
    e.cyc = ec; e.wen = wen; e.addr = a; e.data = d; e.drop = dr;
    sbq.push_back(e);
  endtask

  // The monitor checks every write or drop against the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wb_wen === 1'b1 || drop === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: wen=%0b drop=%0b addr=%0d data=%0h cycle %0d",
                 wb_wen, drop, wb_addr, wb_data, cyc);
      end else begin
        e = sbq.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
        chk("wb_wen",   64'(wb_wen), 64'(e.wen));
        chk("wb_drop",  64'(drop), 64'(e.drop));
        chk("wb_addr",  64'(wb_addr), 64'(e.addr));
        chk("wb_data",  64'(wb_data), 64'(e.data));
      end
    end
  end

  initial begin
    reset_n = 0; alu_valid = 1; alu_addr = 3; alu_data = 32'h1234;
    ld_valid = 1; ld_addr = 4; ld_data = 32'h4444; iss_valid = 0; iss_addr = 0;
    tick; tick;
    chk("rst_wen", 64'(wb_wen), 0);
    chk("rst_drop", 64'(drop), 0);
    chk("rst_addr", 64'(wb_addr), 0);
    chk("rst_data", 64'(wb_data), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_count", 64'(lq_count), 0);
    chk("rst_ready", 64'(ld_ready), 0);
    reset_n = 1; alu_valid = 0; ld_valid = 0;
    #1 chk("ready_before_edge", 64'(ld_ready), 0);
    tick;
    chk("ready_after_release", 64'(ld_ready), 1);

    // Single ALU write
    c = cyc;
    alu_valid = 1; alu_addr = 3; alu_data = 32'hDEADBEEF;
    expw(c + 1, 1, 3, 32'hDEADBEEF, 0);
    tick; alu_valid = 0;
    tick; tick;

    // Contention: the queued loads wait behind three ALU writes
    c = cyc;
    ld_valid = 1; ld_addr = 5; ld_data = 32'h55;
    chk("cont_ready0", 64'(ld_ready), 1);
    expw(c + 2, 1, 2, 32'hA1, 0);
    expw(c + 3, 1, 2, 32'hA2, 0);
    expw(c + 4, 1, 2, 32'hA3, 0);
    expw(c + 5, 1, 5, 32'h55, 0);
    expw(c + 6, 1, 7, 32'h77, 0);
    tick; alu_valid = 1; alu_addr = 2; alu_data = 32'hA1; ld_addr = 7; ld_data = 32'h77;
    chk("cont_count1", 64'(lq_count), 1);
    tick; alu_data = 32'hA2; ld_addr = 4; ld_data = 32'h44;
    chk("cont_count2", 64'(lq_count), 2);
    chk("cont_full_ready", 64'(ld_ready), 0);
    tick; alu_data = 32'hA3; ld_valid = 0;
    chk("cont_third_rejected", 64'(lq_count), 2);
    tick; alu_valid = 0;
    chk("cont_count_c4", 64'(lq_count), 2);
    tick; chk("cont_count_c5", 64'(lq_count), 1);
    tick; chk("cont_count_c6", 64'(lq_count), 0);
    tick;

    // Protected registers: ALU to r0, then a queued load to r1
    c = cyc;
    alu_valid = 1; alu_addr = 0; alu_data = 32'h12;
    expw(c + 1, 0, 7, 32'h77, 1);
    tick; alu_valid = 0;
    tick;
    c = cyc;
    ld_valid = 1; ld_addr = 1; ld_data = 32'h11;
    expw(c + 2, 1, 3, 32'h33, 0);
    expw(c + 3, 0, 3, 32'h33, 1);
    tick; ld_valid = 0; alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
    chk("prot_count_q", 64'(lq_count), 1);
    tick; alu_valid = 0;
    chk("prot_count_held", 64'(lq_count), 1);
    tick; chk("prot_count_popped", 64'(lq_count), 0);
    tick;

    // Scoreboard set and clear
    c = cyc;
    iss_valid = 1; iss_addr = 6;
    tick; iss_valid = 0;
    chk("busy_set", 64'(busy), 64'h40);
    ld_valid = 1; ld_addr = 6; ld_data = 32'h66;
    expw(c + 3, 1, 6, 32'h66, 0);
    tick; ld_valid = 0;
    chk("busy_pending", 64'(busy), 64'h40);
    tick; chk("busy_cleared", 64'(busy), 0);
    // A set and a clear of the same bit in one cycle: the set wins
    c = cyc;
    iss_valid = 1; iss_addr = 6;
    tick; iss_valid = 0; ld_valid = 1; ld_addr = 6; ld_data = 32'h67;
    chk("busy_set2", 64'(busy), 64'h40);
    expw(c + 3, 1, 6, 32'h67, 0);
    tick; ld_valid = 0; iss_valid = 1; iss_addr = 6;
    tick; iss_valid = 1; iss_addr = 1;
    chk("busy_set_wins", 64'(busy), 64'h40);
    tick; iss_valid = 0;
    chk("busy_r1_ignored", 64'(busy), 64'h40);

    // Reset mid-operation with two queued loads and busy = 0x60
    c = cyc;
    iss_valid = 1; iss_addr = 5;
    alu_valid = 1; alu_addr = 2; alu_data = 32'hB1;
    ld_valid = 1; ld_addr = 5; ld_data = 32'h5A;
    expw(c + 1, 1, 2, 32'hB1, 0);
    expw(c + 2, 1, 2, 32'hB2, 0);
    tick; iss_valid = 0; alu_data = 32'hB2; ld_addr = 6; ld_data = 32'h6A;
    tick; alu_valid = 0; ld_valid = 0;
    chk("mid_count", 64'(lq_count), 2);
    chk("mid_busy", 64'(busy), 64'h60);
    reset_n = 0;
    tick; reset_n = 1;
    chk("mid_rst_count", 64'(lq_count), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_wen", 64'(wb_wen), 0);
    repeat (4) tick;
    chk("post_rst_count", 64'(lq_count), 0);
    chk("post_rst_ready", 64'(ld_ready), 1);
    chk("sb_drained", 64'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
